// File: rtl/fir_pkg.sv
// Shared definitions for the FIR input feeder slice.
// Default widths, FIFO geometry and the feeder FSM states.
package fir_pkg;

    localparam int FIR_DATA_W = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int HOLD_TAPS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Ring FIFO holding samples waiting to enter the buffer chain.
// Read data is combinational from the head entry.
module fir_sample_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/fir_input_feeder.sv
// Feeds one sample at a time into the FIR buffer chain, then
// freezes the chain for TAPS cycles while the MAC consumes it.
module fir_input_feeder
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int TAPS   = HOLD_TAPS,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] buf_data,
    output logic              buf_enable,
    output logic              buf_flags,
    output logic              mac_start,
    output logic [LVL_W-1:0]  fifo_level
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [DATA_W-1:0]  head_data;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot
    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_SHIFT);

    fir_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .rd_data   (head_data),
        .level     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            buf_data   <= '0;
            buf_enable <= 1'b0;
            buf_flags  <= 1'b0;
            mac_start  <= 1'b0;
        end else begin
            mac_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    buf_flags <= 1'b0;
                    if (!empty) begin
                        state      <= ST_SHIFT;
                        buf_data   <= head_data;
                        buf_enable <= 1'b1;
                    end else begin
                        buf_enable <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    state      <= ST_HOLD;
                    cnt        <= CNT_W'(TAPS - 1);
                    buf_enable <= 1'b1;
                    buf_flags  <= 1'b1;
                    mac_start  <= 1'b1;
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!empty) begin
                        state      <= ST_SHIFT;
                        buf_data   <= head_data;
                        buf_enable <= 1'b1;
                        buf_flags  <= 1'b0;
                    end else begin
                        state      <= ST_IDLE;
                        buf_enable <= 1'b0;
                        buf_flags  <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    buf_enable <= 1'b0;
                    buf_flags  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_input_feeder.sv
// Bench for fir_input_feeder: a TAPS=8 and a TAPS=1 instance checked
// every cycle against a sample-list / cycles-since-shift reference.
module tb_fir_input_feeder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        v    [2];
    logic [31:0] din  [2];
    logic        rdy  [2];
    logic [31:0] bd   [2];
    logic        be   [2];
    logic        bf   [2];
    logic        ms   [2];
    logic [2:0]  lvl  [2];

    int tests = 0;
    int fails = 0;

    // Reference: queued samples as an ever-growing list [hd, tl),
    // t = cycles since the current SHIFT began (0 = idle).
    logic [31:0] md [2][1024];
    int          hd [2];
    int          tl [2];
    int          t  [2];
    logic [31:0] ebd[2];

    always #5 clk = ~clk;

    fir_input_feeder #(.DATA_W(32), .DEPTH(DEPTH), .TAPS(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v[0]), .in_data(din[0]),
        .in_ready(rdy[0]), .buf_data(bd[0]), .buf_enable(be[0]),
        .buf_flags(bf[0]), .mac_start(ms[0]), .fifo_level(lvl[0])
    );

    fir_input_feeder #(.DATA_W(32), .DEPTH(DEPTH), .TAPS(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v[1]), .in_data(din[1]),
        .in_ready(rdy[1]), .buf_data(bd[1]), .buf_enable(be[1]),
        .buf_flags(bf[1]), .mac_start(ms[1]), .fifo_level(lvl[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int id);
        int taps;
        int sz;
        bit push;
        taps = (id == 0) ? 8 : 1;
        if (reset) begin
            hd[id] = 0; tl[id] = 0; t[id] = 0; ebd[id] = '0;
        end else begin
            sz   = tl[id] - hd[id];
            push = v[id] && (sz < DEPTH);
            if (t[id] == 1) begin
                hd[id]++;
                t[id] = 2;
            end else if (t[id] >= 2 && t[id] <= taps) begin
                t[id]++;
            end else if (sz > 0) begin
                ebd[id] = md[id][hd[id]];
                t[id]   = 1;
            end else begin
                t[id] = 0;
            end
            if (push) begin
                md[id][tl[id]] = din[id];
                tl[id]++;
            end
        end
    endtask

    task automatic check_dut(input int id);
        int sz;
        sz = tl[id] - hd[id];
        chk($sformatf("d%0d.buf_data", id), bd[id], ebd[id]);
        chk($sformatf("d%0d.buf_enable", id), be[id], t[id] != 0);
        chk($sformatf("d%0d.buf_flags", id), bf[id], t[id] >= 2);
        chk($sformatf("d%0d.mac_start", id), ms[id], t[id] == 2);
        chk($sformatf("d%0d.fifo_level", id), lvl[id], sz);
        chk($sformatf("d%0d.in_ready", id), rdy[id], !reset && sz < DEPTH);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        bit acc;
        bit got;
        bit saw_full;
        int nms;

        reset = 1'b1;
        v[0] = 1'b0; v[1] = 1'b0;
        din[0] = '0; din[1] = '0;
        repeat (2) step();
        chk("reset_in_ready", rdy[0], 1'b0);
        chk("reset_level", lvl[0], 3'd0);
        reset = 1'b0;
        step();

        // single sample: shift one cycle after the push edge, then 8 hold cycles
        v[0] = 1'b1; din[0] = 32'hDEAD_BEEF;
        step();
        v[0] = 1'b0;
        step();
        chk("t1_shift_data", bd[0], 32'hDEAD_BEEF);
        chk("t1_shift_en", be[0], 1'b1);
        chk("t1_shift_flags", bf[0], 1'b0);
        step();
        chk("t1_mac_start", ms[0], 1'b1);
        chk("t1_hold_flags", bf[0], 1'b1);
        repeat (12) step();
        chk("t1_back_idle", be[0], 1'b0);

        // burst of 6 with in_valid held; FIFO fills and back-pressures
        saw_full = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            v[0] = 1'b1; din[0] = 32'(i);
            acc = 1'b0;
            for (int w = 0; w < 100 && !acc; w++) begin
                acc = rdy[0];
                step();
                if (lvl[0] == 3'd4) begin
                    saw_full = 1'b1;
                    chk("t3_full_blocks", rdy[0], 1'b0);
                end
            end
            chk("t2_accept_timeout", acc, 1'b1);
        end
        v[0] = 1'b0;
        chk("t2_reached_full", saw_full, 1'b1);
        repeat (70) step();
        chk("t2_drained", lvl[0], 3'd0);

        // reset in the 3rd hold cycle with two samples queued
        for (int i = 0; i < 3; i++) begin
            v[0] = 1'b1; din[0] = $urandom;
            step();
        end
        v[0] = 1'b0;
        got = 1'b0;
        for (int w = 0; w < 50 && !got; w++) begin
            if (ms[0]) got = 1'b1;
            else step();
        end
        chk("t5_mac_seen", got, 1'b1);
        chk("t5_queued", lvl[0], 3'd2);
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("t5_rst_en", be[0], 1'b0);
        chk("t5_rst_flags", bf[0], 1'b0);
        chk("t5_rst_data", bd[0], 32'd0);
        chk("t5_rst_level", lvl[0], 3'd0);
        chk("t5_rst_ready", rdy[0], 1'b0);
        reset = 1'b0;
        step();
        chk("t5_ready_after", rdy[0], 1'b1);

        // TAPS=1 instance: shift/hold alternate, mac_start every 2nd cycle
        nms = 0;
        for (int i = 0; i < 3; i++) begin
            v[1] = 1'b1; din[1] = 32'hA0 + 32'(i);
            step();
            nms += int'(ms[1]);
        end
        v[1] = 1'b0;
        repeat (8) begin
            step();
            nms += int'(ms[1]);
        end
        chk("t6_mac_count", nms, 3);

        // random traffic on both instances, with occasional resets
        for (int c = 0; c < 400; c++) begin
            reset  = ($urandom_range(0, 59) == 0);
            v[0]   = 1'($urandom_range(0, 1));
            v[1]   = 1'($urandom_range(0, 1));
            din[0] = $urandom;
            din[1] = $urandom;
            step();
        end
        reset = 1'b0;
        v[0] = 1'b0; v[1] = 1'b0;
        repeat (60) step();
        chk("rand_drain0", lvl[0], 3'd0);
        chk("rand_drain1", lvl[1], 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
